// File: rtl/fa_pipe_nbit.sv
// fa_pipe_nbit -- pipelined ripple-carry adder, {co, s} = a + b + ci.
//
// The WIDTH-bit carry chain is cut into STAGES chunks of CHUNK = WIDTH/STAGES
// bits. Stage k adds chunk k and registers its carry for stage k+1. Operand
// bits that have not been consumed yet travel forward with the data. Sum
// bits accumulate from the LSB upward. One result per clock, latency STAGES.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b/ci are valid
//   in_ready   block can take operands this cycle (= not stalled)
//   a, b       WIDTH-bit unsigned operands
//   ci         carry in
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   s          WIDTH-bit sum
//   co         carry out of bit WIDTH-1
//   ovf        (only with FA_PIPE_OVERFLOW_EN) two's-complement overflow
//
// Build option: define FA_PIPE_OVERFLOW_EN to add the registered ovf output.

module fa_pipe_nbit #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef FA_PIPE_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = (STAGES > 0) ? (WIDTH / STAGES) : 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("fa_pipe_nbit: WIDTH (%0d) must be a non-zero multiple of STAGES (%0d)",
           WIDTH, STAGES);
  end

  // The whole pipeline moves or holds as one unit. Nothing moves only while a
  // valid result waits at the output.
  logic stall;
  logic advance;

  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = advance;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    // Operand bits still needed from this stage on: global bits
    // [WIDTH-1 : gi*CHUNK]. Local bit 0 is the LSB of this stage's chunk.
    localparam int W_IN = WIDTH - gi * CHUNK;

    logic [W_IN-1:0]          opa_src;
    logic [W_IN-1:0]          opb_src;
    logic                     cin_src;
    logic                     vld_src;
    logic [CHUNK:0]           sum_part;
    logic [(gi+1)*CHUNK-1:0]  sum_next;

    logic                     vld_reg;
    logic                     cy_reg;
    logic [(gi+1)*CHUNK-1:0]  sum_reg;

    if (gi == 0) begin : g_head
      assign opa_src  = a;
      assign opb_src  = b;
      assign cin_src  = ci;
      assign vld_src  = in_valid;
      assign sum_next = sum_part[CHUNK-1:0];
    end else begin : g_body
      assign opa_src  = g_stage[gi-1].g_fwd.opa_reg;
      assign opb_src  = g_stage[gi-1].g_fwd.opb_reg;
      assign cin_src  = g_stage[gi-1].cy_reg;
      assign vld_src  = g_stage[gi-1].vld_reg;
      // New chunk goes above the lower sum bits already computed.
      assign sum_next = {sum_part[CHUNK-1:0], g_stage[gi-1].sum_reg};
    end

    assign sum_part = {1'b0, opa_src[CHUNK-1:0]}
                    + {1'b0, opb_src[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, cin_src};

    // Data registers load only for valid entries. A bubble leaves the old
    // result in place, so s/co keep the last real sum while out_valid is 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_reg <= 1'b0;
        cy_reg  <= 1'b0;
        sum_reg <= '0;
      end else if (advance) begin
        vld_reg <= vld_src;
        if (vld_src) begin
          cy_reg  <= sum_part[CHUNK];
          sum_reg <= sum_next;
        end
      end
    end

    // Pass the unconsumed upper operand bits to the next stage. The last
    // stage has none left to pass on.
    if (gi < STAGES - 1) begin : g_fwd
      logic [W_IN-CHUNK-1:0] opa_reg;
      logic [W_IN-CHUNK-1:0] opb_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opa_reg <= '0;
          opb_reg <= '0;
        end else if (advance && vld_src) begin
          opa_reg <= opa_src[W_IN-1:CHUNK];
          opb_reg <= opb_src[W_IN-1:CHUNK];
        end
      end
    end

`ifdef FA_PIPE_OVERFLOW_EN
    // Signed overflow: both operands have the same sign and the sum sign
    // differs from it. This equals carry-in(MSB) xor carry-out(MSB). The
    // operand MSBs are only present in the last stage's chunk.
    if (gi == STAGES - 1) begin : g_ovf
      logic ovf_next;
      logic ovf_reg;

      assign ovf_next = (opa_src[CHUNK-1] ~^ opb_src[CHUNK-1])
                      & (sum_part[CHUNK-1] ^ opa_src[CHUNK-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_reg <= 1'b0;
        end else if (advance && vld_src) begin
          ovf_reg <= ovf_next;
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].vld_reg;
  assign s         = g_stage[STAGES-1].sum_reg;
  assign co        = g_stage[STAGES-1].cy_reg;
`ifdef FA_PIPE_OVERFLOW_EN
  assign ovf       = g_stage[STAGES-1].g_ovf.ovf_reg;
`endif

endmodule

// File: tb/tb_fa_pipe_nbit.sv
// Directed bench for fa_pipe_nbit: main instance WIDTH=16/STAGES=4, plus
// STAGES=1 and STAGES=16 instances that share the stimulus.
module tb_fa_pipe_nbit;

`ifdef FA_PIPE_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready, ci;
  logic [15:0] a, b;

  logic        in_ready, out_valid, co;
  logic [15:0] s;
  logic        rdy1, vld1, co1;
  logic [15:0] s1;
  logic        rdy16, vld16, co16;
  logic [15:0] s16;
  logic        ov4, ov1, ov16;

  fa_pipe_nbit #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co)
`ifdef FA_PIPE_OVERFLOW_EN
    , .ovf(ov4)
`endif
  );

  fa_pipe_nbit #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .ci(ci), .out_valid(vld1), .out_ready(out_ready),
    .s(s1), .co(co1)
`ifdef FA_PIPE_OVERFLOW_EN
    , .ovf(ov1)
`endif
  );

  fa_pipe_nbit #(.WIDTH(16), .STAGES(16)) u_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
    .a(a), .b(b), .ci(ci), .out_valid(vld16), .out_ready(out_ready),
    .s(s16), .co(co16)
`ifdef FA_PIPE_OVERFLOW_EN
    , .ovf(ov16)
`endif
  );

`ifndef FA_PIPE_OVERFLOW_EN
  assign ov4  = 1'b0;
  assign ov1  = 1'b0;
  assign ov16 = 1'b0;
`endif

  // Observed results packed as {ovf, co, s}.
  logic [31:0] r4, r1, r16;
  assign r4  = {14'b0, ov4,  co,   s};
  assign r1  = {14'b0, ov1,  co1,  s1};
  assign r16 = {14'b0, ov16, co16, s16};

  int n_cmp = 0;
  int n_bad = 0;
  bit sweep_on = 1'b0;
  logic [31:0] q4[$], q1[$], q16[$];

  // Hand-computed vectors: a, b, ci -> s, co, ovf
  logic [15:0] va_t [8] = '{16'h0001, 16'h00FF, 16'h0F0F, 16'h8000,
                            16'h1111, 16'hABCD, 16'hFFFF, 16'h0FFF};
  logic [15:0] vb_t [8] = '{16'h0001, 16'h0001, 16'hF0F0, 16'h8000,
                            16'h2222, 16'h1234, 16'hFFFF, 16'h0001};
  logic        vc_t [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] es_t [8] = '{16'h0002, 16'h0100, 16'h0000, 16'h0000,
                            16'h3334, 16'hBE01, 16'hFFFF, 16'h1000};
  logic        eco_t[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        eov_t[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic logic [31:0] pack(input logic [15:0] ps, input logic pco,
                                       input logic pov);
    return {14'b0, pov & OVF_ON, pco, ps};
  endfunction

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    logic [16:0] r;
    r = {1'b0, x} + {1'b0, y} + {16'b0, c};
    return pack(r[15:0], r[16], (x[15] == y[15]) && (r[15] != x[15]));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_t(input int k);
    in_valid = 1'b1;
    a = va_t[k];
    b = vb_t[k];
    ci = vc_t[k];
  endtask

  // One isolated addition on the main instance: latency, result, hold.
  task automatic run_single(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                            input logic xc, input logic [31:0] exp);
    @(posedge clk); #1;
    in_valid = 1'b1; a = xa; b = xb; ci = xc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk({tag, "_vld"}, {31'b0, out_valid}, {31'b0, (i == 4)});
    end
    chk({tag, "_res"}, r4, exp);
    @(negedge clk);
    chk({tag, "_vld_after"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_hold"}, r4, exp);
    $display("single %s a=%h b=%h ci=%0d -> %h", tag, xa, xb, xc, r4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboards for the corner sweep, one per instance.
  always @(negedge clk) begin
    if (sweep_on && out_valid) begin
      chk("sweep4_avail", {31'b0, q4.size() != 0}, 32'd1);
      if (q4.size() != 0) chk("sweep4_res", r4, q4.pop_front());
    end
  end
  always @(negedge clk) begin
    if (sweep_on && vld1) begin
      chk("sweep1_avail", {31'b0, q1.size() != 0}, 32'd1);
      if (q1.size() != 0) chk("sweep1_res", r1, q1.pop_front());
    end
  end
  always @(negedge clk) begin
    if (sweep_on && vld16) begin
      chk("sweep16_avail", {31'b0, q16.size() != 0}, 32'd1);
      if (q16.size() != 0) chk("sweep16_res", r16, q16.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ci = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_vld4", {31'b0, out_valid}, 32'd0);
    chk("rst_res4", r4, 32'd0);
    chk("rst_rdy4", {31'b0, in_ready}, 32'd1);
    chk("rst_vld1", {31'b0, vld1}, 32'd0);
    chk("rst_res1", r1, 32'd0);
    chk("rst_vld16", {31'b0, vld16}, 32'd0);
    chk("rst_res16", r16, 32'd0);
    $display("reset: out_valid=%0d s=%h co=%0d in_ready=%0d", out_valid, s, co, in_ready);
    rst_n = 1'b1;

    // Isolated additions
    run_single("basic", 16'h1234, 16'h4321, 1'b0, pack(16'h5555, 1'b0, 1'b0));
    run_single("ripple", 16'hFFFF, 16'h0000, 1'b1, pack(16'h0000, 1'b1, 1'b0));
`ifdef FA_PIPE_OVERFLOW_EN
    run_single("ovf", 16'h7FFF, 16'h0001, 1'b0, pack(16'h8000, 1'b0, 1'b1));
`endif

    // Back-to-back stream of 8 vectors
    for (int t = 0; t < 13; t++) begin
      @(posedge clk); #1;
      if (t < 8) drive_t(t);
      else in_valid = 1'b0;
      @(negedge clk);
      chk("stream_vld", {31'b0, out_valid}, {31'b0, (t >= 4 && t < 12)});
      if (t >= 4 && t < 12) begin
        chk("stream_res", r4, pack(es_t[t-4], eco_t[t-4], eov_t[t-4]));
        $display("stream t=%0d result %h", t, r4);
      end
    end

    // Stall for 3 cycles with in_valid held; junk operands while not ready
    for (int t = 0; t < 14; t++) begin
      @(posedge clk); #1;
      out_ready = (t >= 4 && t <= 6) ? 1'b0 : 1'b1;
      if (t < 4) drive_t(t + 2);
      else if (t < 7) begin
        in_valid = 1'b1; a = 16'hDEAD; b = 16'hBEEF; ci = 1'b1;
      end
      else if (t == 7) drive_t(6);
      else if (t == 8) drive_t(7);
      else in_valid = 1'b0;
      @(negedge clk);
      chk("stall_rdy", {31'b0, in_ready}, {31'b0, !(t >= 4 && t <= 6)});
      chk("stall_vld", {31'b0, out_valid}, {31'b0, (t >= 4 && t <= 12)});
      if (t >= 4 && t <= 12) begin
        int k;
        k = (t <= 7) ? 2 : (t - 7 + 2);
        chk("stall_res", r4, pack(es_t[k], eco_t[k], eov_t[k]));
        $display("stall t=%0d out_ready=%0d result %h", t, out_ready, r4);
      end
    end

    // Reset with 3 results in flight
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      drive_t(t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", {31'b0, out_valid}, 32'd0);
    chk("midrst_res", r4, 32'd0);
    $display("mid-op reset: out_valid=%0d s=%h co=%0d", out_valid, s, co);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_vld", {31'b0, out_valid}, 32'd0);
      chk("post_rst_res", r4, 32'd0);
    end

    // Latency of STAGES=1, 4 and 16 on one addition
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'hA5A5; b = 16'h5A5A; ci = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("lat4_vld", {31'b0, out_valid}, {31'b0, (i == 4)});
      chk("lat1_vld", {31'b0, vld1}, {31'b0, (i == 1)});
      chk("lat16_vld", {31'b0, vld16}, {31'b0, (i == 16)});
    end
    chk("lat4_res", r4, pack(16'h0000, 1'b1, 1'b0));
    chk("lat1_res", r1, pack(16'h0000, 1'b1, 1'b0));
    chk("lat16_res", r16, pack(16'h0000, 1'b1, 1'b0));
    $display("latency: s4=%h s1=%h s16=%h", r4, r1, r16);

    // Corner sweep: every replicated 4-bit pattern pair, both carry-ins
    @(posedge clk); #1;
    sweep_on = 1'b1;
    for (int pa = 0; pa < 16; pa++) begin
      for (int pb = 0; pb < 16; pb++) begin
        for (int c = 0; c < 2; c++) begin
          logic [3:0] na, nb;
          logic [31:0] e;
          na = pa[3:0];
          nb = pb[3:0];
          in_valid = 1'b1;
          a = {4{na}};
          b = {4{nb}};
          ci = c[0];
          e = model(a, b, ci);
          q4.push_back(e);
          q1.push_back(e);
          q16.push_back(e);
          @(posedge clk); #1;
        end
      end
      $display("sweep a-pattern %h issued", pa[3:0]);
    end
    in_valid = 1'b0;
    repeat (24) @(negedge clk);
    sweep_on = 1'b0;
    chk("sweep4_drained", q4.size(), 32'd0);
    chk("sweep1_drained", q1.size(), 32'd0);
    chk("sweep16_drained", q16.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
